// File: rtl/branch_commit_unit.sv
// Commit stage for resolved control-flow instructions: checks the fetch-time prediction,
// drives the predictor update bus and the front-end redirect, and counts branches/mispredicts.
module branch_commit_unit #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ex_valid_i,
  input  logic                        ex_is_cond_i,
  input  logic                        ex_is_uncond_i,
  input  logic                        ex_br_taken_i,
  input  logic [31:0]                 ex_pc_i,
  input  logic [31:0]                 ex_target_i,
  input  logic                        ex_btb_hit_i,
  input  logic                        ex_prediction_i,
  input  logic [31:0]                 ex_pred_target_i,
  input  logic [HISTORY_WIDTH-1:0]    ex_ghr_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic                        cm_is_jmp_o,
  output logic                        cm_br_decision_o,
  output logic                        cm_btb_hit_o,
  output logic                        cm_prediction_o,
  output logic [INDEX_WIDTH-1:0]      cm_btb_wr_index_o,
  output logic [32-INDEX_WIDTH-3:0]   cm_btb_wr_tag_o,
  output logic [31:0]                 cm_btb_wr_target_o,
  output logic [HISTORY_WIDTH-1:0]    cm_pht_wr_index_o,
  output logic [HISTORY_WIDTH-1:0]    cm_ghr_data_o,
  output logic                        redirect_o,
  output logic [31:0]                 redirect_pc_o,
  output logic                        flush_front_o,
  output logic [CNT_WIDTH-1:0]        br_cnt_o,
  output logic [CNT_WIDTH-1:0]        mispred_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    sat_inc = (cnt == {CNT_WIDTH{1'b1}}) ? cnt : cnt + CNT_ONE;
  endfunction

  logic                     vld_p1;
  logic                     fired_p1;
  logic                     is_uncond_p1;
  logic                     br_taken_p1;
  logic [31:0]              pc_p1;
  logic [31:0]              target_p1;
  logic                     btb_hit_p1;
  logic                     prediction_p1;
  logic [31:0]              pred_target_p1;
  logic [HISTORY_WIDTH-1:0] ghr_p1;

  logic                     taken;
  logic [31:0]              next_pc;
  logic                     mispred;
  logic                     live;

  // EX -> MEM commit register; fired_p1 keeps a stalled entry from updating twice
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1         <= 1'b0;
      fired_p1       <= 1'b0;
      is_uncond_p1   <= 1'b0;
      br_taken_p1    <= 1'b0;
      pc_p1          <= '0;
      target_p1      <= '0;
      btb_hit_p1     <= 1'b0;
      prediction_p1  <= 1'b0;
      pred_target_p1 <= '0;
      ghr_p1         <= '0;
    end else if (!stall_i) begin
      vld_p1         <= ex_valid_i & (ex_is_cond_i | ex_is_uncond_i) & ~redirect_o & ~flush_i;
      fired_p1       <= 1'b0;
      is_uncond_p1   <= ex_is_uncond_i;
      br_taken_p1    <= ex_br_taken_i;
      pc_p1          <= ex_pc_i;
      target_p1      <= ex_target_i;
      btb_hit_p1     <= ex_btb_hit_i;
      prediction_p1  <= ex_prediction_i;
      pred_target_p1 <= ex_pred_target_i;
      ghr_p1         <= ex_ghr_i;
    end else begin
      if (flush_i) vld_p1 <= 1'b0;
      if (live)    fired_p1 <= 1'b1;
    end
  end

  // MEM: resolve and compare against the fetch-time prediction
  assign taken   = is_uncond_p1 | br_taken_p1;
  assign next_pc = taken ? target_p1 : pc_p1 + 32'd4;
  assign mispred = (taken != prediction_p1) |
                   (taken & prediction_p1 & (target_p1 != pred_target_p1));
  assign live    = vld_p1 & ~fired_p1 & ~flush_i;

  assign cm_is_jmp_o        = live;
  assign cm_br_decision_o   = taken;
  assign cm_btb_hit_o       = btb_hit_p1;
  assign cm_prediction_o    = prediction_p1;
  assign cm_btb_wr_index_o  = pc_p1[INDEX_WIDTH+1:2];
  assign cm_btb_wr_tag_o    = pc_p1[31:INDEX_WIDTH+2];
  assign cm_btb_wr_target_o = target_p1;
  assign cm_pht_wr_index_o  = pc_p1[HISTORY_WIDTH+1:2];
  assign cm_ghr_data_o      = ghr_p1;
  assign redirect_o         = live & mispred;
  assign flush_front_o      = live & mispred;
  assign redirect_pc_o      = (live & mispred) ? next_pc : 32'd0;

  // Performance counters saturate rather than wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
    end else if (live) begin
      br_cnt_o <= sat_inc(br_cnt_o);
      if (mispred) mispred_cnt_o <= sat_inc(mispred_cnt_o);
    end
  end

endmodule

// File: tb/tb_branch_commit_unit.sv
// Directed bench for branch_commit_unit (CNT_WIDTH=4 so saturation is reachable).
module tb_branch_commit_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_cond, ex_is_uncond, ex_br_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_btb_hit, ex_prediction;
  logic [7:0]  ex_ghr;
  logic        stall, flush;
  logic        cm_is_jmp, cm_br_decision, cm_btb_hit, cm_prediction;
  logic [5:0]  cm_btb_wr_index;
  logic [23:0] cm_btb_wr_tag;
  logic [31:0] cm_btb_wr_target;
  logic [7:0]  cm_pht_wr_index, cm_ghr_data;
  logic        redirect, flush_front;
  logic [31:0] redirect_pc;
  logic [3:0]  br_cnt, mispred_cnt;

  int checks = 0;
  int failures = 0;

  branch_commit_unit #(.INDEX_WIDTH(6), .HISTORY_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_is_cond_i(ex_is_cond), .ex_is_uncond_i(ex_is_uncond),
    .ex_br_taken_i(ex_br_taken), .ex_pc_i(ex_pc), .ex_target_i(ex_target),
    .ex_btb_hit_i(ex_btb_hit), .ex_prediction_i(ex_prediction),
    .ex_pred_target_i(ex_pred_target), .ex_ghr_i(ex_ghr),
    .stall_i(stall), .flush_i(flush),
    .cm_is_jmp_o(cm_is_jmp), .cm_br_decision_o(cm_br_decision),
    .cm_btb_hit_o(cm_btb_hit), .cm_prediction_o(cm_prediction),
    .cm_btb_wr_index_o(cm_btb_wr_index), .cm_btb_wr_tag_o(cm_btb_wr_tag),
    .cm_btb_wr_target_o(cm_btb_wr_target), .cm_pht_wr_index_o(cm_pht_wr_index),
    .cm_ghr_data_o(cm_ghr_data), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
    .flush_front_o(flush_front), .br_cnt_o(br_cnt), .mispred_cnt_o(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic c, input logic u, input logic t,
                       input logic [31:0] p, input logic [31:0] tg, input logic h,
                       input logic pr, input logic [31:0] pt, input logic [7:0] g);
    ex_valid = v; ex_is_cond = c; ex_is_uncond = u; ex_br_taken = t;
    ex_pc = p; ex_target = tg; ex_btb_hit = h; ex_prediction = pr;
    ex_pred_target = pt; ex_ghr = g;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 8'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bubble();
    stall = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 1, 32'h100, 32'h180, 1, 0, 32'h0, 8'hFF);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (cm_is_jmp !== 1'b0) begin failures++; $display("FAIL reset_is_jmp got=%0h exp=0", cm_is_jmp); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%0h exp=0", redirect); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%0h exp=0", redirect_pc); end
    checks++; if (cm_btb_wr_target !== 32'h0) begin failures++; $display("FAIL reset_target got=%0h exp=0", cm_btb_wr_target); end
    checks++; if (cm_ghr_data !== 8'h0) begin failures++; $display("FAIL reset_ghr got=%0h exp=0", cm_ghr_data); end
    checks++; if (br_cnt !== 4'h0 || mispred_cnt !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", br_cnt, mispred_cnt); end
    do_reset();
  endtask

  task automatic test_cond_taken_correct();
    do_reset();
    drive(1, 1, 0, 1, 32'h100, 32'h180, 1, 1, 32'h180, 8'hA5);
    tick();
    bubble();
    checks++; if (cm_is_jmp !== 1'b1) begin failures++; $display("FAIL ct_is_jmp got=%0h exp=1", cm_is_jmp); end
    checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL ct_redirect got=%0h exp=0", redirect); end
    checks++; if (cm_btb_wr_index !== 6'h00) begin failures++; $display("FAIL ct_btb_index got=%0h exp=0", cm_btb_wr_index); end
    checks++; if (cm_pht_wr_index !== 8'h40) begin failures++; $display("FAIL ct_pht_index got=%0h exp=40", cm_pht_wr_index); end
    checks++; if (cm_btb_wr_tag !== 24'h000001) begin failures++; $display("FAIL ct_tag got=%0h exp=1", cm_btb_wr_tag); end
    checks++; if (cm_btb_wr_target !== 32'h180 || cm_ghr_data !== 8'hA5) begin failures++; $display("FAIL ct_fields got=%0h/%0h exp=180/a5", cm_btb_wr_target, cm_ghr_data); end
    checks++; if (cm_br_decision !== 1'b1 || cm_btb_hit !== 1'b1 || cm_prediction !== 1'b1) begin failures++; $display("FAIL ct_flags got=%0b%0b%0b exp=111", cm_br_decision, cm_btb_hit, cm_prediction); end
    checks++; if (br_cnt !== 4'd0) begin failures++; $display("FAIL ct_cnt_early got=%0d exp=0", br_cnt); end
    tick();
    checks++; if (cm_is_jmp !== 1'b0) begin failures++; $display("FAIL ct_is_jmp_after got=%0h exp=0", cm_is_jmp); end
    checks++; if (br_cnt !== 4'd1 || mispred_cnt !== 4'd0) begin failures++; $display("FAIL ct_cnt got=%0d/%0d exp=1/0", br_cnt, mispred_cnt); end
  endtask

  task automatic test_cond_mispredict();
    do_reset();
    drive(1, 1, 0, 0, 32'h200, 32'h280, 1, 1, 32'h280, 8'h00);
    tick();
    // wrong-path branch in EX: would itself mispredict if it were captured
    drive(1, 1, 0, 1, 32'h204, 32'h900, 0, 0, 32'h0, 8'h00);
    checks++; if (redirect !== 1'b1 || flush_front !== 1'b1) begin failures++; $display("FAIL mp_redirect got=%0h/%0h exp=1/1", redirect, flush_front); end
    checks++; if (redirect_pc !== 32'h204) begin failures++; $display("FAIL mp_redirect_pc got=%0h exp=204", redirect_pc); end
    checks++; if (cm_br_decision !== 1'b0) begin failures++; $display("FAIL mp_decision got=%0h exp=0", cm_br_decision); end
    tick();
    bubble();
    checks++; if (cm_is_jmp !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL mp_bubble got=%0h/%0h exp=0/0", cm_is_jmp, redirect); end
    checks++; if (br_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin failures++; $display("FAIL mp_cnt got=%0d/%0d exp=1/1", br_cnt, mispred_cnt); end
    tick();
    checks++; if (br_cnt !== 4'd1) begin failures++; $display("FAIL mp_cnt_hold got=%0d exp=1", br_cnt); end
  endtask

  task automatic test_jal();
    do_reset();
    drive(1, 0, 1, 0, 32'h300, 32'h400, 0, 0, 32'h0, 8'h00);
    tick();
    bubble();
    checks++; if (cm_br_decision !== 1'b1) begin failures++; $display("FAIL jal_decision got=%0h exp=1", cm_br_decision); end
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL jal_redirect got=%0h pc=%0h exp=1 pc=400", redirect, redirect_pc); end
    tick();
    drive(1, 0, 1, 0, 32'h300, 32'h400, 1, 1, 32'h3F0, 8'h00);
    tick();
    bubble();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL jal_tgt_redirect got=%0h pc=%0h exp=1 pc=400", redirect, redirect_pc); end
    tick();
    drive(1, 0, 1, 0, 32'h300, 32'h400, 1, 1, 32'h400, 8'h00);
    tick();
    bubble();
    checks++; if (cm_is_jmp !== 1'b1 || redirect !== 1'b0) begin failures++; $display("FAIL jal_correct got=%0h/%0h exp=1/0", cm_is_jmp, redirect); end
    tick();
    checks++; if (br_cnt !== 4'd3 || mispred_cnt !== 4'd2) begin failures++; $display("FAIL jal_cnt got=%0d/%0d exp=3/2", br_cnt, mispred_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1, 1, 0, 0, 32'h200, 32'h280, 0, 1, 32'h280, 8'h00);
    tick();
    bubble();
    stall = 1'b1;
    checks++; if (redirect !== 1'b1 || cm_is_jmp !== 1'b1) begin failures++; $display("FAIL st_first got=%0h/%0h exp=1/1", redirect, cm_is_jmp); end
    tick();
    checks++; if (redirect !== 1'b0 || cm_is_jmp !== 1'b0) begin failures++; $display("FAIL st_second got=%0h/%0h exp=0/0", redirect, cm_is_jmp); end
    checks++; if (cm_btb_wr_target !== 32'h280) begin failures++; $display("FAIL st_hold got=%0h exp=280", cm_btb_wr_target); end
    tick();
    checks++; if (redirect !== 1'b0 || br_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin failures++; $display("FAIL st_third got=%0h cnt=%0d/%0d exp=0 cnt=1/1", redirect, br_cnt, mispred_cnt); end
    stall = 1'b0;
    tick();
    checks++; if (br_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin failures++; $display("FAIL st_cnt got=%0d/%0d exp=1/1", br_cnt, mispred_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 0, 0, 32'h200, 32'h280, 0, 1, 32'h280, 8'h00);
    tick();
    flush = 1'b1;
    drive(1, 1, 0, 0, 32'h500, 32'h580, 0, 1, 32'h580, 8'h00);
    #1;
    checks++; if (cm_is_jmp !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 32'h0) begin failures++; $display("FAIL fl_kill got=%0h/%0h pc=%0h exp=0/0 pc=0", cm_is_jmp, redirect, redirect_pc); end
    tick();
    flush = 1'b0;
    bubble();
    checks++; if (cm_is_jmp !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL fl_bubble got=%0h/%0h exp=0/0", cm_is_jmp, redirect); end
    checks++; if (br_cnt !== 4'd0 || mispred_cnt !== 4'd0) begin failures++; $display("FAIL fl_cnt got=%0d/%0d exp=0/0", br_cnt, mispred_cnt); end
    tick();
    checks++; if (br_cnt !== 4'd0) begin failures++; $display("FAIL fl_cnt_after got=%0d exp=0", br_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 0, 1, 32'h600, 32'h700, 1, 1, 32'h700, 8'h11);
    tick();
    drive(1, 1, 0, 0, 32'h604, 32'h6F0, 0, 0, 32'h0, 8'h22);
    checks++; if (cm_is_jmp !== 1'b1 || redirect !== 1'b0) begin failures++; $display("FAIL b2b_a got=%0h/%0h exp=1/0", cm_is_jmp, redirect); end
    tick();
    drive(1, 1, 0, 1, 32'h608, 32'h800, 0, 0, 32'h0, 8'h33);
    checks++; if (cm_is_jmp !== 1'b1 || redirect !== 1'b0 || br_cnt !== 4'd1) begin failures++; $display("FAIL b2b_b got=%0h/%0h cnt=%0d exp=1/0 cnt=1", cm_is_jmp, redirect, br_cnt); end
    tick();
    drive(1, 0, 0, 1, 32'h60C, 32'h900, 0, 0, 32'h0, 8'h44);
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h800 || br_cnt !== 4'd2) begin failures++; $display("FAIL b2b_c got=%0h pc=%0h cnt=%0d exp=1 pc=800 cnt=2", redirect, redirect_pc, br_cnt); end
    tick();
    // non-branch valid instruction right after: still a bubble
    drive(1, 0, 0, 1, 32'h610, 32'h900, 0, 0, 32'h0, 8'h55);
    checks++; if (br_cnt !== 4'd3 || mispred_cnt !== 4'd1) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=3/1", br_cnt, mispred_cnt); end
    tick();
    bubble();
    checks++; if (cm_is_jmp !== 1'b0 || cm_ghr_data !== 8'h55) begin failures++; $display("FAIL b2b_nonbranch got=%0h ghr=%0h exp=0 ghr=55", cm_is_jmp, cm_ghr_data); end
    drive(1, 1, 0, 0, 32'hFFFFFFFC, 32'h10, 0, 1, 32'h10, 8'h00);
    tick();
    bubble();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap got=%0h pc=%0h exp=1 pc=0", redirect, redirect_pc); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 0, 0, 32'h200, 32'h280, 0, 1, 32'h280, 8'h00);
      tick();
      bubble();
      tick();
    end
    checks++; if (mispred_cnt !== 4'hF || br_cnt !== 4'hF) begin failures++; $display("FAIL sat_fill got=%0h/%0h exp=f/f", br_cnt, mispred_cnt); end
    drive(1, 1, 0, 0, 32'h200, 32'h280, 0, 1, 32'h280, 8'h00);
    tick();
    bubble();
    stall = 1'b1;
    checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL sat_live got=%0h exp=1", redirect); end
    tick();
    checks++; if (mispred_cnt !== 4'hF || br_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0h/%0h exp=f/f", br_cnt, mispred_cnt); end
    // async reset mid-stall, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mispred_cnt !== 4'h0 || br_cnt !== 4'h0) begin failures++; $display("FAIL async_cnt got=%0h/%0h exp=0/0", br_cnt, mispred_cnt); end
    checks++; if (cm_btb_wr_target !== 32'h0 || cm_btb_wr_tag !== 24'h0 || cm_br_decision !== 1'b0) begin failures++; $display("FAIL async_fields got=%0h/%0h/%0h exp=0/0/0", cm_btb_wr_target, cm_btb_wr_tag, cm_br_decision); end
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    bubble();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_cond_taken_correct();
    test_cond_mispredict();
    test_jal();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
